// File: rtl/response_checker.sv
// Response checker: compares a swept stream of single-bit responses against a latched
// truth table, counting mismatches, flagging ordering errors and compacting a signature.
`timescale 1ns/1ps

// state  | meaning
// S_IDLE | waiting for start after reset
// S_CHECK| sweep in progress, records accepted on in_valid
// S_DONE | sweep finished, results held until next start
module response_checker #(
    parameter int          VEC_W    = 4,
    parameter logic [15:0] SIG_POLY = 16'h1021
) (
    input  logic                    CK,
    input  logic                    reset,
    input  logic                    start,
    input  logic [(1<<VEC_W)-1:0]   golden,
    input  logic                    in_valid,
    input  logic [VEC_W-1:0]        in_vec,
    input  logic                    in_resp,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [VEC_W:0]          mismatch_cnt,
    output logic                    fail_seen,
    output logic [VEC_W-1:0]        first_fail,
    output logic                    seq_err,
    output logic [15:0]             signature
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

    localparam logic [VEC_W:0] MM_MAX = {1'b1, {VEC_W{1'b0}}};

    state_t                  state_q, state_d;
    logic [VEC_W-1:0]        exp_q, exp_d;
    logic [(1<<VEC_W)-1:0]   gold_q, gold_d;
    logic [VEC_W:0]          mm_d;
    logic                    ff_d, seq_d, pass_d, busy_d, done_d, mis;
    logic [VEC_W-1:0]        first_d;
    logic [15:0]             sig_d, sig_feed;

    assign mis      = in_resp != gold_q[in_vec];
    assign sig_feed = {{(16-VEC_W-1){1'b0}}, in_vec, in_resp};

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        gold_d  = gold_q;
        mm_d    = mismatch_cnt;
        ff_d    = fail_seen;
        first_d = first_fail;
        seq_d   = seq_err;
        sig_d   = signature;
        pass_d  = pass;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CHECK;
                    gold_d  = golden;
                    exp_d   = '0;
                    mm_d    = '0;
                    ff_d    = 1'b0;
                    first_d = '0;
                    seq_d   = 1'b0;
                    sig_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            S_CHECK: begin
                if (in_valid) begin
                    exp_d = exp_q + 1'b1;
                    if (mis) begin
                        if (mismatch_cnt != MM_MAX)
                            mm_d = mismatch_cnt + 1'b1;
                        if (!fail_seen) begin
                            ff_d    = 1'b1;
                            first_d = in_vec;
                        end
                    end
                    if (in_vec != exp_q)
                        seq_d = 1'b1;
                    sig_d = {signature[14:0], 1'b0} ^ (signature[15] ? SIG_POLY : 16'h0000) ^ sig_feed;
                    // pass reflects the final record as well, so it uses the next-state values
                    if (exp_q == '1) begin
                        state_d = S_DONE;
                        pass_d  = (mm_d == '0) && !seq_d;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            exp_q        <= '0;
            gold_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            fail_seen    <= 1'b0;
            first_fail   <= '0;
            seq_err      <= 1'b0;
            signature    <= '0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            gold_q       <= gold_d;
            busy         <= busy_d;
            done         <= done_d;
            pass         <= pass_d;
            mismatch_cnt <= mm_d;
            fail_seen    <= ff_d;
            first_fail   <= first_d;
            seq_err      <= seq_d;
            signature    <= sig_d;
        end
    end

endmodule

// File: doc/response_checker.md
RESPONSE_CHECKER -- requirements
Module: response_checker

Interface
REQ-001 Parameter: VEC_W, default 4, stimulus vector width; sweep length is 2^VEC_W records.
REQ-002 Parameter: SIG_POLY, default 16'h1021, feedback polynomial of the 16-bit response signature register.
REQ-003 Port: CK  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port: start  input  1  one-cycle request to begin a sweep.
REQ-006 Port: golden  input  2^VEC_W  expected-response truth table; bit k is the expected output for vector k.
REQ-007 Port: in_valid  input  1  a record (vector plus response) is presented this cycle.
REQ-008 Port: in_vec  input  VEC_W  applied stimulus vector of the record.
REQ-009 Port: in_resp  input  1  single-bit response observed for in_vec.
REQ-010 Port: busy  output  1  high while in CHECK.
REQ-011 Port: done  output  1  sweep complete, held until the next accepted start or reset.
REQ-012 Port: pass  output  1  valid when done is 1: no mismatches and no sequence error.
REQ-013 Port: mismatch_cnt  output  VEC_W+1  number of records whose response differed from golden.
REQ-014 Port: fail_seen  output  1  at least one mismatch in the current sweep.
REQ-015 Port: first_fail  output  VEC_W  in_vec of the first mismatching record.
REQ-016 Port: seq_err  output  1  sticky: a record arrived out of ascending order.
REQ-017 Port: signature  output  16  running response signature.

Function
REQ-018 FSM states: IDLE, CHECK, DONE; all outputs are registered.
REQ-019 IDLE or DONE with start=1: latch golden into gold_q, clear all counters and flags, set expected index exp=0, enter CHECK next cycle.
REQ-020 start while in CHECK: ignored, with no restart and no latching.
REQ-021 in_valid in IDLE or DONE, including the same cycle as start: record ignored.
REQ-022 CHECK with in_valid=1: record accepted; all updates are visible the following cycle.
REQ-023 Mismatch is in_resp != gold_q[in_vec]; on mismatch, mismatch_cnt increments; if fail_seen=0, first_fail is set to in_vec and fail_seen to 1.
REQ-024 in_vec != exp on an accepted record: seq_err is set and stays set; checking still uses in_vec as the index.
REQ-025 exp increments by 1 per accepted record, independent of in_vec.
REQ-026 Signature update per accepted record: sig = (sig<<1) XOR (sig[15] ? SIG_POLY : 0) XOR zero-extended {in_vec, in_resp}.
REQ-027 Accepted record with exp = 2^VEC_W-1: enter DONE next cycle; done rises and pass = (mismatch_cnt==0 && !seq_err), including that last record.
REQ-028 mismatch_cnt width VEC_W+1 holds a maximum of 2^VEC_W; it never wraps.
REQ-029 Gaps are allowed: in_valid low in CHECK holds all state; there is no timeout.
REQ-030 DONE holds all results stable until start or reset.
REQ-031 A new start from DONE clears done, pass, counters, flags, signature and first_fail in the same update as the CHECK entry.

Reset
REQ-032 reset=0 asynchronously forces IDLE, exp=0, gold_q=0, and all outputs to 0 (busy, done, pass, mismatch_cnt, fail_seen, first_fail, seq_err, signature).
REQ-033 reset asserted mid-sweep abandons the sweep; after release the block waits in IDLE for start.
REQ-034 Release is taken on the next CK edge with reset=1; start on that edge is honoured.

Verification
REQ-035 golden=16'h8000, start, then vectors 0..15 one per cycle with in_resp=(vec==15) -> done=1, pass=1, mismatch_cnt=0, seq_err=0, busy=0.
REQ-036 Same sweep but in_resp=1 for vectors 3 and 9 -> mismatch_cnt=2, first_fail=3, fail_seen=1, pass=0.
REQ-037 Vectors sent 0,1,3,2,4..15 with correct responses -> seq_err=1, mismatch_cnt=0, pass=0, done after the 16th record.
REQ-038 in_valid with random gaps and start pulsed mid-sweep -> identical results to REQ-035; start ignored; signature equals a gap-free run.
REQ-039 reset=0 after 7 records -> all outputs 0 immediately (asynchronously); a following full sweep gives pass=1.
REQ-040 golden=16'hFFFF, all in_resp=0 -> mismatch_cnt=16 with no wrap; first_fail=0; then start from DONE -> counters cleared and busy=1 next cycle.
